// File: rtl/cmd_issue_sequencer.sv
// Expands 128-bit PS command words into single-cycle DDR4 command requests
// with per-word repeat count and post-issue delay; exports a status word.
module cmd_issue_sequencer #(
   parameter int unsigned ROW_WIDTH   = 17,
   parameter int unsigned COL_WIDTH   = 10,
   parameter int unsigned DELAY_WIDTH = 16
) (
   input  logic                   c0_ddr4_clk,
   input  logic                   c0_ddr4_rst,
   input  logic [127:0]           S_AXIS_CMD_tdata,
   input  logic                   S_AXIS_CMD_tvalid,
   output logic                   S_AXIS_CMD_tready,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [3:0]             cmd_op,
   output logic [1:0]             cmd_bg,
   output logic [1:0]             cmd_ba,
   output logic [ROW_WIDTH-1:0]   cmd_row,
   output logic [COL_WIDTH-1:0]   cmd_col,
   output logic [31:0]            states
);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_RD   = 4'd4;
   localparam logic [3:0] OP_WR   = 4'd5;
   localparam logic [3:0] OP_ZQCS = 4'd7;
   localparam logic [3:0] OP_WAIT = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DELAY = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   state_t                   r_state;
   logic                     r_valid;
   logic [3:0]               r_op;
   logic [1:0]               r_bg;
   logic [1:0]               r_ba;
   logic [ROW_WIDTH-1:0]     r_row;
   logic [COL_WIDTH-1:0]     r_col;
   logic [DELAY_WIDTH-1:0]   r_dly;
   logic [DELAY_WIDTH-1:0]   r_rep;
   logic [DELAY_WIDTH-1:0]   r_dcnt;
   logic                     r_more;
   logic                     r_err;
   logic [15:0]              r_count;
   logic [31:0]              r_states;

   logic [3:0]               w_op;
   logic [1:0]               w_bg;
   logic [1:0]               w_ba;
   logic [ROW_WIDTH-1:0]     w_row;
   logic [COL_WIDTH-1:0]     w_col;
   logic [DELAY_WIDTH-1:0]   w_delay;
   logic [DELAY_WIDTH-1:0]   w_rep;
   logic                     w_more;
   logic                     w_unused;

   assign w_op     = S_AXIS_CMD_tdata[127:124];
   assign w_bg     = S_AXIS_CMD_tdata[123:122];
   assign w_ba     = S_AXIS_CMD_tdata[121:120];
   assign w_row    = S_AXIS_CMD_tdata[102 +: ROW_WIDTH];
   assign w_col    = S_AXIS_CMD_tdata[92 +: COL_WIDTH];
   assign w_delay  = S_AXIS_CMD_tdata[76 +: DELAY_WIDTH];
   assign w_rep    = S_AXIS_CMD_tdata[60 +: DELAY_WIDTH];
   assign w_unused = ^{S_AXIS_CMD_tdata[59:0], S_AXIS_CMD_tdata[119:102+ROW_WIDTH]};

   // r_rep holds issues still owed after the current one
   assign w_more = (r_rep != '0);

   // Gated by reset so tready is low during reset and high as soon as it releases
   assign S_AXIS_CMD_tready = (r_state == ST_IDLE) && !c0_ddr4_rst;
   assign cmd_valid         = r_valid;
   assign cmd_op            = r_op;
   assign cmd_bg            = r_bg;
   assign cmd_ba            = r_ba;
   assign cmd_row           = r_row;
   assign cmd_col           = r_col;
   assign states            = r_states;

   always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
      if (c0_ddr4_rst) begin
         r_state  <= ST_IDLE;
         r_valid  <= 1'b0;
         r_op     <= '0;
         r_bg     <= '0;
         r_ba     <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_dly    <= '0;
         r_rep    <= '0;
         r_dcnt   <= '0;
         r_more   <= 1'b0;
         r_err    <= 1'b0;
         r_count  <= '0;
         r_states <= '0;
      end else begin
         r_states <= {r_count, 13'd0, r_err, r_state};
         unique case (r_state)
            ST_IDLE: begin
               if (S_AXIS_CMD_tvalid) begin
                  r_op   <= w_op;
                  r_bg   <= w_bg;
                  r_ba   <= w_ba;
                  r_row  <= w_row;
                  r_col  <= w_col;
                  r_dly  <= w_delay;
                  r_rep  <= w_rep;
                  r_more <= 1'b0;
                  if (w_op != OP_NOP && w_op <= OP_ZQCS) begin
                     r_valid <= 1'b1;
                     r_state <= ST_ISSUE;
                  end else if (w_op == OP_WAIT) begin
                     if (w_delay != '0) begin
                        r_dcnt  <= w_delay;
                        r_state <= ST_DELAY;
                     end
                  end else if (w_op != OP_NOP) begin
                     r_err   <= 1'b1;
                     r_state <= ST_ERR;
                  end
               end
            end
            ST_ISSUE: begin
               if (cmd_ready) begin
                  r_count <= r_count + 16'd1;
                  if (r_op == OP_RD || r_op == OP_WR) begin
                     r_col <= r_col + COL_WIDTH'(8);
                  end
                  r_more <= w_more;
                  if (w_more) begin
                     r_rep <= r_rep - DELAY_WIDTH'(1);
                  end
                  if (r_dly != '0) begin
                     r_dcnt  <= r_dly;
                     r_valid <= 1'b0;
                     r_state <= ST_DELAY;
                  end else if (!w_more) begin
                     r_valid <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_DELAY: begin
               if (r_dcnt <= DELAY_WIDTH'(1)) begin
                  if (r_more) begin
                     r_valid <= 1'b1;
                     r_state <= ST_ISSUE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_dcnt <= r_dcnt - DELAY_WIDTH'(1);
               end
            end
            ST_ERR: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_issue_sequencer.sv
// Self-checking bench for cmd_issue_sequencer: directed scenarios plus random
// words checked against a queue of expected issues built from each accepted word.
module tb_cmd_issue_sequencer;

   logic          clk;
   logic          rst;
   logic [127:0]  tdata;
   logic          tvalid;
   logic          tready;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_op;
   logic [1:0]    cmd_bg;
   logic [1:0]    cmd_ba;
   logic [16:0]   cmd_row;
   logic [9:0]    cmd_col;
   logic [31:0]   states;

   cmd_issue_sequencer #(.ROW_WIDTH(17), .COL_WIDTH(10), .DELAY_WIDTH(16)) dut (
      .c0_ddr4_clk       (clk),
      .c0_ddr4_rst       (rst),
      .S_AXIS_CMD_tdata  (tdata),
      .S_AXIS_CMD_tvalid (tvalid),
      .S_AXIS_CMD_tready (tready),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_op            (cmd_op),
      .cmd_bg            (cmd_bg),
      .cmd_ba            (cmd_ba),
      .cmd_row           (cmd_row),
      .cmd_col           (cmd_col),
      .states            (states)
   );

   typedef struct {
      logic [3:0]  op;
      logic [1:0]  bg;
      logic [1:0]  ba;
      logic [16:0] row;
      logic [9:0]  col;
      int          gap;
      bit          first;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   exp_count = 0;
   bit   exp_err  = 0;
   bit   want_new = 1;
   int   last_fire = 0;
   bit   saw_err_state = 0;
   bit   rdy_mode = 0;
   bit   rdy_val  = 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      cmd_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cmd_ready = rdy_mode ? (($urandom % 10) < 7) : rdy_val;
      end
   end

   // Scoreboard: every request must match the next expected issue, appear on the
   // expected cycle, and hold its fields while the scheduler stalls.
   always @(negedge clk) begin
      if (!rst) begin
         if (states[1:0] == 2'd3) saw_err_state = 1;
         if (cmd_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 64'(cmd_valid), 64'd0);
            end else begin
               int exp_at;
               if (want_new) begin
                  exp_at = exp_q[0].first ? exp_q[0].acc : last_fire + exp_q[0].gap + 1;
                  check("issue_cycle", 64'(cyc), 64'(exp_at));
                  want_new = 0;
               end
               check("fields", 64'({cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col}),
                     64'({exp_q[0].op, exp_q[0].bg, exp_q[0].ba, exp_q[0].row, exp_q[0].col}));
               if (cmd_ready) begin
                  void'(exp_q.pop_front());
                  last_fire = cyc;
                  want_new  = 1;
               end
            end
         end
      end
   end

   task automatic send_word(input logic [3:0] op, input logic [1:0] bg, input logic [1:0] ba,
                            input logic [17:0] row, input logic [9:0] col,
                            input logic [15:0] dly, input logic [15:0] rep, output int acc);
      int n = 0;
      exp_t e;
      @(negedge clk);
      tdata  = {op, bg, ba, row, col, dly, rep, 60'({$urandom(), $urandom()})};
      tvalid = 1'b1;
      while (!tready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!tready) begin
         check("accept_timeout", 64'd0, 64'd1);
         tvalid = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      acc = cyc;
      if (op >= 4'd1 && op <= 4'd7) begin
         for (int k = 0; k <= int'(rep); k++) begin
            e.op    = op;
            e.bg    = bg;
            e.ba    = ba;
            e.row   = row[16:0];
            e.col   = (op == 4'd4 || op == 4'd5) ? 10'(int'(col) + 8 * k) : col;
            e.gap   = int'(dly);
            e.first = (k == 0);
            e.acc   = acc;
            exp_q.push_back(e);
            exp_count++;
         end
      end else if (op >= 4'd9) begin
         exp_err = 1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !tready) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) check("drain_timeout", 64'd0, 64'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_states(input string tag);
      check(tag, 64'(states), 64'({16'(exp_count), 13'd0, exp_err, 2'd0}));
   endtask

   task automatic reset_model();
      exp_q.delete();
      exp_count = 0;
      exp_err   = 0;
      want_new  = 1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int a1, a2, op_i, d_i, r_i;
      logic [9:0] c_i;
      rst    = 1'b1;
      tvalid = 1'b0;
      tdata  = '0;
      #12;
      check("rst_tready", 64'(tready), 64'd0);
      check("rst_valid", 64'(cmd_valid), 64'd0);
      check("rst_fields", 64'({cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col}), 64'd0);
      check("rst_states", 64'(states), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("tready_release", 64'(tready), 64'd1);

      // Single ACT, scheduler always ready
      rdy_mode = 0; rdy_val = 1;
      send_word(4'd1, 2'd1, 2'd2, 18'h01234, 10'd0, 16'd0, 16'd0, a1);
      @(negedge clk);
      check("tready_busy", 64'(tready), 64'd0);
      @(negedge clk);
      check("tready_t2", 64'(tready), 64'd1);
      drain();
      check_states("states_act");

      // RD with column wrap, three back-to-back issues
      send_word(4'd4, 2'd0, 2'd3, 18'h3ABCD, 10'h3F0, 16'd0, 16'd2, a1);
      drain();
      check_states("states_rd");

      // WR with delay 3, first issue stalled five cycles
      rdy_val = 0;
      send_word(4'd5, 2'd2, 2'd1, 18'h00777, 10'h010, 16'd3, 16'd1, a1);
      repeat (5) @(negedge clk);
      rdy_val = 1;
      drain();
      check_states("states_wr");

      // WAIT 10 then PRE
      send_word(4'd8, 2'd0, 2'd0, 18'h0, 10'd0, 16'd10, 16'd5, a1);
      send_word(4'd2, 2'd3, 2'd0, 18'h00042, 10'd0, 16'd0, 16'd0, a2);
      check("wait_len", 64'(a2), 64'(a1 + 11));
      drain();

      // Illegal opcode then REF
      saw_err_state = 0;
      send_word(4'hC, 2'd0, 2'd0, 18'h0, 10'd0, 16'd0, 16'd0, a1);
      @(negedge clk);
      check("tready_err", 64'(tready), 64'd0);
      send_word(4'd6, 2'd1, 2'd1, 18'h0, 10'd0, 16'd0, 16'd0, a2);
      drain();
      check_states("states_err");
      check("err_state_seen", 64'(saw_err_state), 64'd1);

      // Reset during DELAY of a repeat=5 word
      send_word(4'd1, 2'd2, 2'd2, 18'h00100, 10'd0, 16'd6, 16'd5, a1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rstd_valid", 64'(cmd_valid), 64'd0);
      check("rstd_states", 64'(states), 64'd0);
      check("rstd_tready", 64'(tready), 64'd0);
      reset_model();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstd_tready_rel", 64'(tready), 64'd1);
      repeat (20) @(negedge clk);
      check_states("rstd_states_after");

      // Reset while a request is stalled in ISSUE
      rdy_val = 0;
      send_word(4'd3, 2'd0, 2'd0, 18'h0, 10'd0, 16'd0, 16'd0, a1);
      @(negedge clk);
      check("rsti_valid_before", 64'(cmd_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rsti_valid", 64'(cmd_valid), 64'd0);
      reset_model();
      @(negedge clk);
      rst = 1'b0;
      rdy_val = 1;
      repeat (5) @(negedge clk);

      // Random words with a randomly stalling scheduler
      rdy_mode = 1;
      for (int i = 0; i < 60; i++) begin
         r_i  = int'($urandom % 20);
         if (r_i < 14)      op_i = (r_i % 7) + 1;
         else if (r_i < 16) op_i = 0;
         else if (r_i < 18) op_i = 8;
         else               op_i = 9 + int'($urandom % 7);
         d_i  = int'($urandom % 4);
         c_i  = ($urandom % 2 == 0) ? 10'(10'h3E0 + ($urandom % 32)) : 10'($urandom);
         send_word(4'(op_i), 2'($urandom), 2'($urandom), 18'($urandom), c_i,
                   16'(d_i), 16'($urandom % 3), a1);
      end
      drain();
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      check_states("states_random");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
